// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared constants and FSM state encoding for the UART
// transmit arbiter (uart_tx_arbiter) and its round-robin picker (rr_pick).
package uart_arb_pkg;

  // Largest number of requesters the 2-bit grant index can address.
  localparam int MAX_REQ = 4;

  // Width of the grant index and of the round-robin pointer.
  localparam int GNT_W = 2;

  // Arbiter FSM: IDLE picks a winner, XFER forwards the winner's bytes.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder. Scans the request
// vector cyclically starting at rr_ptr and reports the first set bit.
// rr_ptr is expected to be in the range 0..N_REQ-1.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GNT_W-1:0] rr_ptr,
  output logic             any,
  output logic [GNT_W-1:0] winner
);

  // First requester at or after rr_ptr (wrapping) wins; later hits are ignored.
  always_comb begin
    int               idx;
    logic [N_REQ-1:0] sel;
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      sel = N_REQ'(1) << idx;
      if (!any && (|(req & sel))) begin
        any    = 1'b1;
        winner = GNT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmit FIFO
// between N_REQ byte-stream requesters.
//
// Handshake (per requester i): req[i] means "data/last hold a valid byte".
// The byte is taken in the cycle ack[i]=1, which is only ever raised for the
// granted requester and only when the UART is not full. Until that ack the
// requester holds req/data/last stable. A grant lasts until the byte marked
// last is accepted; a requester that drops req mid-packet simply stalls its
// own grant.
//
// Optional feature: define UART_ARB_BURST_CAP_EN to also end a grant after
// MAX_BURST accepted bytes; the interrupted requester resumes at its next
// grant. Without the macro the burst counter does not exist.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    tx_full,
  output logic                    wr_uart,
  output logic [DATA_W-1:0]       w_data,
  output logic                    busy,
  output logic [GNT_W-1:0]        gnt_id
);

  // Elaboration-time guard on the parameter ranges this block supports.
  if (N_REQ < 2 || N_REQ > MAX_REQ || MAX_BURST < 1) begin : g_bad_params
    $error("uart_tx_arbiter: N_REQ must be 2..4 and MAX_BURST at least 1");
  end

  arb_state_e       state_q, state_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             pick_any;
  logic [GNT_W-1:0] pick_winner;
  logic             grant_end;

`ifdef UART_ARB_BURST_CAP_EN
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Next-state and output decode: IDLE registers a winner, XFER passes the
  // granted requester's byte straight through whenever the UART has room.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    wr_uart   = 1'b0;
    ack       = '0;
    w_data    = '0;
    grant_end = 1'b0;
`ifdef UART_ARB_BURST_CAP_EN
    bcnt_d    = bcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // No byte moves here; the pointer only moves when a grant ends.
        if (pick_any) begin
          gnt_d   = pick_winner;
          state_d = ST_XFER;
`ifdef UART_ARB_BURST_CAP_EN
          bcnt_d  = '0;
`endif
        end
      end
      ST_XFER: begin
        w_data       = data[gnt_q*DATA_W +: DATA_W];
        wr_uart      = req[gnt_q] & ~tx_full;
        ack[gnt_q]   = wr_uart;
        if (wr_uart) begin
          grant_end = last[gnt_q];
`ifdef UART_ARB_BURST_CAP_EN
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_d == BCNT_W'(MAX_BURST)) begin
            grant_end = 1'b1;
          end
`endif
          if (grant_end) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (gnt_q == GNT_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant, pointer (and burst count) registers; reset drops any packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
`ifdef UART_ARB_BURST_CAP_EN
      bcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef UART_ARB_BURST_CAP_EN
      bcnt_q   <= bcnt_d;
`endif
    end
  end

  assign busy   = (state_q == ST_XFER);
  assign gnt_id = gnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter. A cycle-level
// model of the arbitration rules predicts every output each cycle, a byte
// scoreboard (exp_q) holds the hand-ordered write stream, and literal checks
// pin latency, gaps and reset behaviour. Build with UART_ARB_BURST_CAP_EN
// defined to exercise the burst cap (MAX_BURST is set to 4 here).
module tb_uart_tx_arbiter;

  localparam int N_REQ     = 3;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int PKT_DEPTH = 8;
`ifdef UART_ARB_BURST_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        last;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        ack;
  logic                    tx_full;
  logic                    wr_uart;
  logic [DATA_W-1:0]       w_data;
  logic                    busy;
  logic [1:0]              gnt_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ     (N_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .last    (last),
    .data    (data),
    .ack     (ack),
    .tx_full (tx_full),
    .wr_uart (wr_uart),
    .w_data  (w_data),
    .busy    (busy),
    .gnt_id  (gnt_id)
  );

  // ---------------- requester packet store ----------------
  logic [8:0] pkt_mem [N_REQ][PKT_DEPTH];   // {last, byte}
  int         head [N_REQ];
  int         tail [N_REQ];
  int         hold [N_REQ];                 // cycles to keep req low

  // ---------------- scoreboard / model / counters ----------------
  logic [9:0] exp_q[$];                     // {gnt_id, byte} in write order
  bit         m_busy;
  int         m_gnt, m_ptr, m_bcnt;
  int         n_cmp, n_bad, cyc;
  int         t0, n_wr, first_wr, last_wr;
  logic [7:0] last_wd;
  logic       s_busy;
  logic [1:0] s_gnt;
  logic [N_REQ-1:0] s_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input int r, input logic [7:0] b, input logic l);
    pkt_mem[r][tail[r]] = {l, b};
    tail[r]++;
  endtask

  task automatic expect_wr(input int r, input logic [7:0] b);
    exp_q.push_back({2'(r), b});
  endtask

  task automatic flush();
    for (int i = 0; i < N_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      hold[i] = 0;
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N_REQ; i++) if (head[i] < tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      if (head[i] < tail[i]) begin
        data[i*DATA_W +: DATA_W] = pkt_mem[i][head[i]][7:0];
        req[i]  = (hold[i] == 0);
        last[i] = (hold[i] == 0) ? pkt_mem[i][head[i]][8] : 1'b0;
      end else begin
        data[i*DATA_W +: DATA_W] = '0;
        req[i]  = 1'b0;
        last[i] = 1'b0;
      end
    end
  endtask

  task automatic start_test();
    t0       = cyc;
    n_wr     = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  task automatic reset_dut();
    reset   = 1'b0;
    m_busy  = 1'b0;
    m_gnt   = 0;
    m_ptr   = 0;
    m_bcnt  = 0;
    flush();
    exp_q.delete();
    req     = '0;
    last    = '0;
    data    = '0;
    tx_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model at negedge, then
  // advance the model across the rising edge.
  task automatic cycle();
    bit   acc, found;
    int   nxt;
    logic [7:0] exp_wd;
    apply_inputs();
    @(negedge clk);
    acc    = m_busy && req[m_gnt] && !tx_full;
    exp_wd = m_busy ? data[m_gnt*DATA_W +: DATA_W] : 8'h00;
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_busy) chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
    chk("wr_uart", 32'(wr_uart), 32'(acc));
    chk("ack", 32'(ack), acc ? (32'd1 << m_gnt) : 32'd0);
    chk("w_data", 32'(w_data), 32'(exp_wd));
    s_busy = busy;
    s_gnt  = gnt_id;
    s_ack  = ack;
    if (wr_uart === 1'b1) begin
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      last_wd = w_data;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got id %0d byte 0x%0h expected no write (cycle %0d)",
                 gnt_id, w_data, cyc);
      end else begin
        chk("sb_byte", 32'({gnt_id, w_data}), 32'(exp_q.pop_front()));
      end
    end
    // requesters retire a byte when they see their ack
    for (int i = 0; i < N_REQ; i++) begin
      if (ack[i] === 1'b1 && head[i] < tail[i]) head[i]++;
    end
    @(posedge clk);
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        nxt = (m_ptr + k) % N_REQ;
        if (!found && req[nxt]) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_gnt  = nxt;
          m_bcnt = 0;
        end
      end
    end else if (acc) begin
      m_bcnt++;
      if (last[m_gnt] || (CAP_EN && m_bcnt == MAX_BURST)) begin
        m_busy = 1'b0;
        m_ptr  = (m_gnt + 1) % N_REQ;
      end
    end
    for (int i = 0; i < N_REQ; i++) if (hold[i] > 0) hold[i]--;
    cyc++;
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      done = !m_busy && all_empty() && exp_q.size() == 0;
      if (!done) begin
        cycle();
        n++;
      end
    end
    chk({name, "_drain"}, 32'(done), 32'd1);
    repeat (2) cycle();
    chk({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    flush();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    start_test();
    reset_dut();

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(wr_uart), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wdata", 32'(w_data), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    @(posedge clk);
    #1;

    // Single packet from requester 1
    start_test();
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
    expect_wr(1, 8'h41); expect_wr(1, 8'h42); expect_wr(1, 8'h43);
    cycle();
    chk("t1_busy_at_req", 32'(s_busy), 32'd0);
    cycle();
    chk("t1_busy_next", 32'(s_busy), 32'd1);
    drain("t1");
    chk("t1_latency", 32'(first_wr - t0), 32'd1);
    chk("t1_nwr", 32'(n_wr), 32'd3);
    chk("t1_span", 32'(last_wr - first_wr), 32'd2);
    chk("t1_busy_after", 32'(s_busy), 32'd0);

    // Contention from reset: two rounds of 2-byte packets from all three
    reset_dut();
    start_test();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1); push(0, 8'hD0, 1'b0); push(0, 8'hD1, 1'b1);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1); push(1, 8'hE0, 1'b0); push(1, 8'hE1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1); push(2, 8'hF0, 1'b0); push(2, 8'hF1, 1'b1);
    expect_wr(0, 8'hA0); expect_wr(0, 8'hA1); expect_wr(1, 8'hB0); expect_wr(1, 8'hB1);
    expect_wr(2, 8'hC0); expect_wr(2, 8'hC1); expect_wr(0, 8'hD0); expect_wr(0, 8'hD1);
    expect_wr(1, 8'hE0); expect_wr(1, 8'hE1); expect_wr(2, 8'hF0); expect_wr(2, 8'hF1);
    drain("t2");
    chk("t2_nwr", 32'(n_wr), 32'd12);
    chk("t2_latency", 32'(first_wr - t0), 32'd1);
    chk("t2_span", 32'(last_wr - first_wr), 32'd16);

    // Backpressure: tx_full for 5 cycles after two bytes
    start_test();
    for (int b = 0; b < 5; b++) begin
      push(2, 8'(8'h51 + b), (b == 4));
      expect_wr(2, 8'(8'h51 + b));
    end
    repeat (3) cycle();
    tx_full = 1'b1;
    repeat (5) cycle();
    chk("t3_no_wr_while_full", 32'(n_wr), 32'd2);
    tx_full = 1'b0;
    cycle();
    chk("t3_resume_cycle", 32'(last_wr), 32'(cyc - 1));
    chk("t3_resume_byte", 32'(last_wd), 32'h53);
    drain("t3");
    chk("t3_nwr", 32'(n_wr), 32'd5);

    // Burst cap: requester 0 sends 6 bytes while requester 2 waits
    start_test();
    for (int b = 0; b < 6; b++) push(0, 8'(8'h60 + b), (b == 5));
    push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b1);
`ifdef UART_ARB_BURST_CAP_EN
    for (int b = 0; b < 4; b++) expect_wr(0, 8'(8'h60 + b));
    expect_wr(2, 8'h70); expect_wr(2, 8'h71);
    expect_wr(0, 8'h64); expect_wr(0, 8'h65);
`else
    for (int b = 0; b < 6; b++) expect_wr(0, 8'(8'h60 + b));
    expect_wr(2, 8'h70); expect_wr(2, 8'h71);
`endif
    drain("t4");
    chk("t4_nwr", 32'(n_wr), 32'd8);
    chk("t4_span", 32'(last_wr - first_wr), CAP_EN ? 32'd9 : 32'd8);

    // Reset mid-packet: reset after byte 2 of 5, then a fresh packet
    start_test();
    for (int b = 0; b < 5; b++) push(1, 8'(8'h80 + b), (b == 4));
    expect_wr(1, 8'h80); expect_wr(1, 8'h81);
    repeat (3) cycle();
    chk("t5_sb_before_reset", 32'(exp_q.size()), 32'd0);
    apply_inputs();
    #1 reset = 1'b0;
    #1;
    chk("t5_busy_in_reset", 32'(busy), 32'd0);
    chk("t5_wr_in_reset", 32'(wr_uart), 32'd0);
    chk("t5_ack_in_reset", 32'(ack), 32'd0);
    chk("t5_wdata_in_reset", 32'(w_data), 32'd0);
    reset_dut();
    start_test();
    push(1, 8'h90, 1'b0); push(1, 8'h91, 1'b1);
    expect_wr(1, 8'h90); expect_wr(1, 8'h91);
    drain("t5");
    chk("t5_latency", 32'(first_wr - t0), 32'd1);
    chk("t5_nwr", 32'(n_wr), 32'd2);

    // Requester stall: req[0] drops 3 cycles mid-packet while 1 waits
    start_test();
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b0); push(0, 8'hC3, 1'b1);
    push(1, 8'hD0, 1'b0); push(1, 8'hD1, 1'b1);
    expect_wr(0, 8'hC0); expect_wr(0, 8'hC1); expect_wr(0, 8'hC2); expect_wr(0, 8'hC3);
    expect_wr(1, 8'hD0); expect_wr(1, 8'hD1);
    repeat (3) cycle();
    hold[0] = 3;
    for (int s = 0; s < 3; s++) begin
      cycle();
      chk("t6_stall_busy", 32'(s_busy), 32'd1);
      chk("t6_stall_gnt", 32'(s_gnt), 32'd0);
      chk("t6_stall_ack", 32'(s_ack), 32'd0);
    end
    drain("t6");
    chk("t6_nwr", 32'(n_wr), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one UART transmit FIFO among up to four requesters. Each requester presents byte-wide packets through a req/last/ack handshake. The arbiter grants one requester at a time and forwards its bytes to the UART `wr_uart`/`w_data` port while honouring `tx_full`. A grant is held until the packet's last byte, or until the optional burst cap is reached. Sits between the test/command logic and the `uart` unit's transmit side.

## Interface
- `N_REQ`, 3: number of requesters, 2..4.
- `DATA_W`, 8: byte width; must match the UART `w_data` width.
- `MAX_BURST`, 16: maximum bytes per grant; used only when the burst cap is compiled in.

- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester "byte valid".
- `last`  in  N_REQ  per-requester "this byte ends packet".
- `data`  in  N_REQ*DATA_W  per-requester bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- `ack`  out  N_REQ  one-cycle pulse: byte of requester i accepted this cycle.
- `tx_full`  in  1  UART transmit FIFO full.
- `wr_uart`  out  1  write strobe to the UART.
- `w_data`  out  DATA_W  byte to the UART.
- `busy`  out  1  a grant is active.
- `gnt_id`  out  2  index of the granted requester; valid while `busy`=1.

## Operation
- FSM states: IDLE, XFER.
- IDLE:
  - If any `req` is high, pick a winner round-robin, starting at `rr_ptr`.
  - Register the winner into `gnt_id` and go to XFER. No byte moves in IDLE.
- XFER, with g = `gnt_id`:
  - Acceptance is `wr_uart` = `req[g] & ~tx_full`. This is combinational.
  - `ack[g]` = `wr_uart`.
  - `w_data` = `data[g]` while `busy`; 0 otherwise.
- End of packet: an accepted byte with `last[g]`=1 returns the FSM to IDLE. At the same time `rr_ptr` is set to (g+1) mod N_REQ.
- Requester behaviour during a grant:
  - Non-granted requesters never see `ack`.
  - They must hold `req`/`data`/`last` stable until acked.
  - If `req[g]` drops mid-packet, the grant is held and the FSM stalls in XFER. There is no abort.
- Burst counter `bcnt` (width clog2(MAX_BURST+1)):
  - Cleared on entry to XFER.
  - Increments on each accepted byte.
- Reset (async, any state): FSM=IDLE, `rr_ptr`=0, `gnt_id`=0, `bcnt`=0. Resulting outputs: `busy`=0, `ack`=0, `wr_uart`=0, `w_data`=0.
  - A packet in flight is dropped.
  - The requester must restart the packet from its first byte.

## Timing
- Latency: `req` rises at cycle t while IDLE → `busy`=1 from t+1 → earliest `wr_uart`/`ack` at t+1.
- Steady state: one byte per cycle while `req[g]`=1 and `tx_full`=0.
- Gap between packets: one IDLE cycle after each packet end, during which no write occurs.
- `tx_full` and `req[g]` both high: no write and no ack. The byte is retried every cycle.
- All requesters idle: the arbiter stays in IDLE and `rr_ptr` is unchanged.
- Simultaneous requests at IDLE: the first set bit at or after `rr_ptr` (cyclic) wins.

## Configuration
- `UART_ARB_BURST_CAP_EN` defined:
  - An accepted byte that brings `bcnt` to `MAX_BURST` ends the grant, even when `last`=0.
  - `rr_ptr` advances and the FSM returns to IDLE.
  - The interrupted requester keeps `req` high and resumes its packet at its next grant.
- Not defined: `bcnt` logic is removed, `MAX_BURST` is ignored, and grants end only on `last`.

## Structure
- Package `uart_arb_pkg` holds:
  - the state encoding (`ST_IDLE`, `ST_XFER`);
  - `MAX_REQ`=4;
  - `GNT_W`=2.
- One sub-module, `rr_pick`: combinational round-robin priority encoder.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: `any`, `winner`.
- The arbiter FSM, pointer and counter live in `uart_tx_arbiter`.

## Test plan
- **Single packet:** requester 1 sends 0x41, 0x42, 0x43 (last on 0x43), `tx_full`=0.
  - Expect `busy` one cycle after `req`.
  - Expect `wr_uart` on 3 consecutive cycles with `w_data` 0x41, 0x42, 0x43 and `ack[1]` on each.
  - Expect `busy`=0 afterwards.
- **Contention:** all 3 request 2-byte packets from reset.
  - Grant order is 0, 1, 2.
  - Each packet is separated by exactly one idle cycle.
  - The next contention round starts at 0 again.
- **Backpressure:** `tx_full`=1 for 5 cycles mid-packet.
  - No `wr_uart`/`ack` during those cycles; byte order is preserved.
  - The held byte is written the cycle `tx_full` falls.
- **Burst cap** (`UART_ARB_BURST_CAP_EN`, `MAX_BURST`=4): requester 0 sends 6 bytes while requester 2 is waiting.
  - 4 bytes from 0, then requester 2's packet, then the remaining 2 bytes from 0.
  - Without the macro: all 6 bytes from 0 first.
- **Reset mid-packet:** assert `reset` low after byte 2 of 5.
  - All outputs go to 0 immediately.
  - After release, a new request from requester 1 is granted normally.
- **Requester stall:** `req[g]` drops for 3 cycles mid-packet while another requester waits.
  - `busy` stays 1 and `gnt_id` is unchanged.
  - No other requester is acked until `last` is accepted.
